// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 adder sequencer: field widths, encodings,
// FSM states and the bit positions inside the flags word.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp_eff;
    logic [MAN_W:0]   sig;
    logic             is_inf;
    logic             is_nan;
  } fp_fields_t;

endpackage

// File: rtl/fp32_add_seq_if.sv
// Operand/result handshake bundle between the issue logic, the adder sequencer
// and the writeback stage.
interface fp32_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into sign, effective exponent (subnormals use 1),
// significand with hidden bit, and the inf/NaN classification.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0] op,
  output fp_fields_t  fields
);

  always_comb begin
    fields.sign    = op[31];
    fields.exp_eff = (op[30:23] == 8'd0) ? 8'd1 : op[30:23];
    fields.sig     = {(op[30:23] != 8'd0), op[22:0]};
    fields.is_inf  = (op[30:23] == 8'hFF) && (op[22:0] == 23'd0);
    fields.is_nan  = (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
  end

endmodule

// File: rtl/fp32_add_seq.sv
// Multi-cycle binary32 adder: one FSM steps a shared unpack/align/add/norm/round
// datapath. Define FP32_ADD_RNE_EN for round-to-nearest-even, otherwise truncation.
module fp32_add_seq
  import fp32_pkg::*;
#(
  parameter int ALIGN_MAX = 26
)
(
  input logic          clk,
  input logic          rst,
  fp32_add_seq_if.slave bus
);

  localparam logic [7:0] ALIGN_CAP = 8'(ALIGN_MAX);
  localparam logic [9:0] EXP_TOP   = 10'(EXP_MAX);

  state_t      state_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] result_r;
  logic [2:0]  flags_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sx_r;
  logic        sy_r;
  logic [9:0]  ex_r;
  logic [27:0] xm_r;
  logic [27:0] ym_r;
  logic [7:0]  cnt_r;

  fp_fields_t  fa_s;
  fp_fields_t  fb_s;
  logic        x_sign_s, y_sign_s;
  logic [7:0]  x_exp_s, y_exp_s;
  logic [23:0] x_sig_s, y_sig_s;
  logic [7:0]  gap_s;
  logic [7:0]  d_s;
  logic        special_s;
  logic [31:0] spec_res_s;
  logic [2:0]  spec_flags_s;
  logic [27:0] sum_s;
  logic [27:0] add_man_s;
  logic [9:0]  add_exp_s;
  logic        add_norm_s;
  logic        norm_more_s;
  logic        inexact_s;
  logic        round_up_s;
  logic [24:0] rnd_sum_s;
  logic [23:0] rnd_sig_s;
  logic [9:0]  rnd_exp_s;
  logic [31:0] rnd_res_s;
  logic [2:0]  rnd_flags_s;

  fp32_unpack u_unpack_a (.op(a_r), .fields(fa_s));
  fp32_unpack u_unpack_b (.op(b_r), .fields(fb_s));

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;

  // Magnitude ordering, alignment distance and special-operand decode.
  always_comb begin
    // Raw bits order magnitudes correctly, subnormals included.
    if (b_r[30:0] > a_r[30:0]) begin
      x_sign_s = fb_s.sign; x_exp_s = fb_s.exp_eff; x_sig_s = fb_s.sig;
      y_sign_s = fa_s.sign; y_exp_s = fa_s.exp_eff; y_sig_s = fa_s.sig;
    end else begin
      x_sign_s = fa_s.sign; x_exp_s = fa_s.exp_eff; x_sig_s = fa_s.sig;
      y_sign_s = fb_s.sign; y_exp_s = fb_s.exp_eff; y_sig_s = fb_s.sig;
    end
    gap_s = x_exp_s - y_exp_s;
    if (gap_s > ALIGN_CAP) begin
      d_s = ALIGN_CAP;
    end else begin
      d_s = gap_s;
    end
    special_s    = 1'b0;
    spec_res_s   = 32'd0;
    spec_flags_s = 3'b000;
    if (fa_s.is_nan || fb_s.is_nan ||
        (fa_s.is_inf && fb_s.is_inf && (fa_s.sign != fb_s.sign))) begin
      special_s                  = 1'b1;
      spec_res_s                 = FP32_QNAN;
      spec_flags_s[FLAG_INVALID] = 1'b1;
    end else if (fa_s.is_inf) begin
      special_s  = 1'b1;
      spec_res_s = a_r;
    end else if (fb_s.is_inf) begin
      special_s  = 1'b1;
      spec_res_s = b_r;
    end else begin
      special_s = 1'b0;
    end
  end

  // Mantissa add/subtract with carry renormalisation, plus NORM loop control.
  always_comb begin
    if (sx_r == sy_r) begin
      sum_s = xm_r + ym_r;
    end else begin
      sum_s = xm_r - ym_r;
    end
    if (sum_s[27]) begin
      add_man_s = {1'b0, sum_s[27:2], sum_s[1] | sum_s[0]};
      add_exp_s = ex_r + 10'd1;
    end else begin
      add_man_s = sum_s;
      add_exp_s = ex_r;
    end
    add_norm_s  = (add_man_s != 28'd0) && !add_man_s[26] && (add_exp_s > 10'd1);
    norm_more_s = !xm_r[25] && (ex_r > 10'd2);
  end

  // Rounding on guard/round/sticky and final packing.
  always_comb begin
    inexact_s = |xm_r[2:0];
`ifdef FP32_ADD_RNE_EN
    round_up_s = xm_r[2] & (xm_r[1] | xm_r[0] | xm_r[3]);
`else
    round_up_s = 1'b0;
`endif
    rnd_sum_s = {1'b0, xm_r[26:3]} + {24'd0, round_up_s};
    if (rnd_sum_s[24]) begin
      rnd_sig_s = rnd_sum_s[24:1];
      rnd_exp_s = ex_r + 10'd1;
    end else begin
      rnd_sig_s = rnd_sum_s[23:0];
      rnd_exp_s = ex_r;
    end
    rnd_flags_s = 3'b000;
    if (xm_r == 28'd0) begin
      rnd_res_s = {sx_r & sy_r, 31'd0};
    end else if (rnd_exp_s >= EXP_TOP) begin
`ifdef FP32_ADD_RNE_EN
      rnd_res_s = {sx_r, 8'hFF, 23'd0};
`else
      rnd_res_s = {sx_r, 31'h7F7F_FFFF};
`endif
      rnd_flags_s[FLAG_OVERFLOW] = 1'b1;
      rnd_flags_s[FLAG_INEXACT]  = 1'b1;
    end else begin
      rnd_res_s = {sx_r, (rnd_sig_s[23] ? rnd_exp_s[7:0] : 8'd0), rnd_sig_s[22:0]};
      rnd_flags_s[FLAG_INEXACT] = inexact_s;
    end
  end

  // Controller and datapath registers; handshake outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      flags_r     <= 3'b000;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sx_r        <= 1'b0;
      sy_r        <= 1'b0;
      ex_r        <= 10'd0;
      xm_r        <= 28'd0;
      ym_r        <= 28'd0;
      cnt_r       <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.op_a;
            b_r        <= {bus.op_b[31] ^ bus.sub, bus.op_b[30:0]};
            in_ready_r <= 1'b0;
            state_r    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (special_s) begin
            result_r    <= spec_res_s;
            flags_r     <= spec_flags_s;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            sx_r    <= x_sign_s;
            sy_r    <= y_sign_s;
            ex_r    <= {2'b00, x_exp_s};
            xm_r    <= {1'b0, x_sig_s, 3'b000};
            ym_r    <= {1'b0, y_sig_s, 3'b000};
            cnt_r   <= d_s;
            state_r <= (d_s == 8'd0) ? S_ADD : S_ALIGN;
          end
        end
        S_ALIGN: begin
          ym_r  <= {1'b0, ym_r[27:2], ym_r[1] | ym_r[0]};
          cnt_r <= cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            state_r <= S_ADD;
          end
        end
        S_ADD: begin
          xm_r    <= add_man_s;
          ex_r    <= add_exp_s;
          state_r <= add_norm_s ? S_NORM : S_ROUND;
        end
        S_NORM: begin
          xm_r <= {xm_r[26:0], 1'b0};
          ex_r <= ex_r - 10'd1;
          if (!norm_more_s) begin
            state_r <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_r    <= rnd_res_s;
          flags_r     <= rnd_flags_s;
          out_valid_r <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_seq.sv
// Bench for fp32_add_seq: directed cases with known sums and latencies, then
// random operand pairs checked against an exact-arithmetic rounding model.
module tb_fp32_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  fp32_add_seq_if bus();

  fp32_add_seq #(.ALIGN_MAX(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Exact value = signed integer significand sum scaled by 2^(emin-150), then rounded.
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b0, input logic s,
                         output logic [31:0] r, output logic [2:0] f);
    logic [31:0]  b;
    logic [299:0] va, vb, mag, q, rem, half;
    logic         sgn, inx, nan_a, nan_b, inf_a, inf_b;
    int           ea, eb, emin, p, et, sh;
    b = b0;
    b[31] = b0[31] ^ s;
    r = 32'd0;
    f = 3'b000;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
      r = 32'h7FC0_0000;
      f = 3'b100;
    end else if (inf_a) begin
      r = a;
    end else if (inf_b) begin
      r = b;
    end else begin
      ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      emin = (ea < eb) ? ea : eb;
      va = {276'd0, (a[30:23] != 8'd0), a[22:0]};
      vb = {276'd0, (b[30:23] != 8'd0), b[22:0]};
      va = va << (ea - emin);
      vb = vb << (eb - emin);
      if (a[31] == b[31]) begin
        mag = va + vb; sgn = a[31];
      end else if (va >= vb) begin
        mag = va - vb; sgn = a[31];
      end else begin
        mag = vb - va; sgn = b[31];
      end
      if (mag == 300'd0) begin
        r = {a[31] & b[31], 31'd0};
      end else begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        et = p + emin - 23;
        if (et < 1) et = 1;
        sh = et - emin;
        inx = 1'b0;
        if (sh <= 0) begin
          q = mag << (-sh);
        end else begin
          q    = mag >> sh;
          rem  = mag & ((300'd1 << sh) - 300'd1);
          half = 300'd1 << (sh - 1);
          inx  = (rem != 300'd0);
`ifdef FP32_ADD_RNE_EN
          if ((rem > half) || ((rem == half) && q[0])) q = q + 300'd1;
`endif
        end
        if (q[24]) begin
          q  = q >> 1;
          et = et + 1;
        end
        if (et >= 255) begin
`ifdef FP32_ADD_RNE_EN
          r = {sgn, 8'hFF, 23'd0};
`else
          r = {sgn, 31'h7F7F_FFFF};
`endif
          f = 3'b011;
        end else begin
          r = {sgn, (q[23] ? 8'(et) : 8'd0), q[22:0]};
          f = {2'b00, inx};
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] near);
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:             v[30:23] = 8'd0;
      1:             v[30:0]  = 31'd0;
      2:             v[30:0]  = 31'h7F80_0000;
      3:             begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      4, 5, 6, 7, 8: v[30:23] = near + 8'($urandom_range(0, 4)) - 8'd2;
      9:             v[30:23] = 8'd254 - 8'($urandom_range(0, 1));
      default:       v = v;
    endcase
    return v;
  endfunction

  // Drives one operand pair; returns at the falling edge after the accept edge.
  task automatic start_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.sub = s; bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.sub = 1'b1;
  endtask

  // Waits for out_valid while offering a junk operand pair that must be ignored.
  task automatic wait_result(inout int lat);
    bus.in_valid = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_result();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("in_ready_after_take", {31'd0, bus.in_ready}, 32'd1);
    check_eq("out_valid_after_take", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic [2:0] ef,
                          input int elat);
    int lat;
    start_txn(a, b, s, lat);
    wait_result(lat);
    check_eq({tag, "_res"}, bus.result, er);
    check_eq({tag, "_flg"}, {29'd0, bus.flags}, {29'd0, ef});
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    take_result();
  endtask

  logic [31:0] ra, rb, er, ovf_res;
  logic [2:0]  ef;
  logic        rs;
  int          lat;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_a = 32'd0; bus.op_b = 32'd0; bus.sub = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_flags", {29'd0, bus.flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef FP32_ADD_RNE_EN
    ovf_res = 32'h7F80_0000;
`else
    ovf_res = 32'h7F7F_FFFF;
`endif
    directed("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, 5);
    directed("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, 4);
    directed("negz_plus_negz", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b000, 4);
    directed("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 2);
    directed("max_plus_max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, ovf_res, 3'b011, 4);
    directed("tie_even", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b001, 28);
    directed("align_cap", 32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000, 3'b001, 30);
    directed("subn_add", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 3'b000, 4);
    directed("cancel_norm", 32'h4000_0000, 32'h3FFF_FFFF, 1'b1, 32'h3400_0000, 3'b000, 29);

    // Backpressure: outputs frozen and no new accept while the result waits.
    start_txn(32'h3F80_0000, 32'h4000_0000, 1'b0, lat);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_result", bus.result, 32'h4040_0000);
      check_eq("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    take_result();

    // Reset in the middle of a long alignment discards the operation.
    start_txn(32'h3F80_0000, 32'h0000_0001, 1'b0, lat);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("midrst_flags", {29'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i % 7 == 0) begin
        check_eq("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      end
    end

    for (int t = 0; t < 400; t++) begin
      ra = rand_op(8'($urandom_range(1, 254)));
      rb = rand_op(ra[30:23]);
      rs = 1'($urandom_range(0, 1));
      ref_add(ra, rb, rs, er, ef);
      start_txn(ra, rb, rs, lat);
      wait_result(lat);
      check_eq($sformatf("rnd_res a=%h b=%h sub=%0d", ra, rb, rs), bus.result, er);
      check_eq($sformatf("rnd_flg a=%h b=%h sub=%0d", ra, rb, rs), {29'd0, bus.flags}, {29'd0, ef});
      take_result();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
